// File: rtl/f_seq_detector.sv
// f_seq_detector: Moore FSM that finds the serial pattern 1011 in a stream
// of qualified bits. It also keeps the last 8 accepted bits, pulses
// byte_ready after every 8th accepted bit, and counts detections in a
// saturating counter. Every output comes straight from a flop.
module f_seq_detector #(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f,
    input  logic             f_valid,
    output logic             z,
    output logic [7:0]       shreg,
    output logic             byte_ready,
    output logic [CNT_W-1:0] hits
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HITS_MAX = '1;
    localparam logic [CNT_W-1:0] HITS_ONE = 1;

    state_t     state;
    state_t     nxt;
    logic [2:0] bit_cnt;

    // Next-state function. Without an accepted bit the state holds, which
    // also keeps z high in S1011 across f_valid gaps. Unused encodings fall
    // back to S0 whether or not a bit is accepted.
    always_comb begin
        nxt = state;
        case (state)
            S0:      if (f_valid) nxt = f ? S1    : S0;
            S1:      if (f_valid) nxt = f ? S1    : S10;
            S10:     if (f_valid) nxt = f ? S101  : S0;
            S101:    if (f_valid) nxt = f ? S1011 : S10;
            S1011:   if (f_valid) nxt = f ? S1 : ((OVERLAP != 0) ? S10 : S0);
            default: nxt = S0;
        endcase
    end

    // State, registered outputs, shift register, bit counter and hit counter.
    // z is computed from the next state so that it is high exactly while the
    // state register holds S1011.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S0;
            z          <= 1'b0;
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_ready <= 1'b0;
            hits       <= '0;
        end else begin
            state      <= nxt;
            z          <= (nxt == S1011);
            // Pulse only on the accepted bit that wraps the counter 7 -> 0.
            byte_ready <= f_valid && (bit_cnt == 3'd7);
            if (f_valid) begin
                shreg   <= {shreg[6:0], f};
                bit_cnt <= bit_cnt + 3'd1;
                // The only way into S1011 is S101 followed by an accepted 1.
                if ((state == S101) && f && (hits != HITS_MAX))
                    hits <= hits + HITS_ONE;
            end
        end
    end

endmodule

// File: tb/tb_f_seq_detector.sv
// tb_f_seq_detector: directed stimulus driven into three detector variants
// (overlapping, non-overlapping, overlapping with 2-bit hit counter).
// Expected outputs for each edge are queued by the stimulus; a monitor pops
// and compares them just after the edge.
module tb_f_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       f = 1'b0;
    logic       f_valid = 1'b0;

    logic       z_a, br_a, z_b, br_b, z_c, br_c;
    logic [7:0] sh_a, sh_b, sh_c;
    logic [7:0] hits_a, hits_b;
    logic [1:0] hits_c;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic       z;
        logic [7:0] sh;
        logic       shc;
        logic       br;
        logic [7:0] h;
        logic       z0;
        logic [7:0] h0;
        logic [1:0] hs;
    } exp_t;

    exp_t q[$];
    exp_t last;

    f_seq_detector #(.OVERLAP(1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .f(f), .f_valid(f_valid),
        .z(z_a), .shreg(sh_a), .byte_ready(br_a), .hits(hits_a));

    f_seq_detector #(.OVERLAP(0), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .f(f), .f_valid(f_valid),
        .z(z_b), .shreg(sh_b), .byte_ready(br_b), .hits(hits_b));

    f_seq_detector #(.OVERLAP(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .f(f), .f_valid(f_valid),
        .z(z_c), .shreg(sh_c), .byte_ready(br_c), .hits(hits_c));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue one accepted bit and its expected post-edge outputs.
    task automatic step(input logic fb, input logic ez, input logic [7:0] esh,
                        input logic eshc, input logic ebr, input logic [7:0] eh,
                        input logic ez0, input logic [7:0] eh0, input logic [1:0] ehs);
        exp_t e;
        e.z = ez; e.sh = esh; e.shc = eshc; e.br = ebr; e.h = eh;
        e.z0 = ez0; e.h0 = eh0; e.hs = ehs;
        last = e;
        f = fb;
        f_valid = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Idle edge: everything holds except byte_ready, which must be low.
    task automatic gap(input logic fb);
        exp_t e;
        e = last;
        e.br = 1'b0;
        e.shc = 1'b1;
        last = e;
        f = fb;
        f_valid = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, " z_ov"}, 32'(z_a), 0);
        chk({tag, " shreg_ov"}, 32'(sh_a), 0);
        chk({tag, " br_ov"}, 32'(br_a), 0);
        chk({tag, " hits_ov"}, 32'(hits_a), 0);
        chk({tag, " z_nov"}, 32'(z_b), 0);
        chk({tag, " hits_nov"}, 32'(hits_b), 0);
        chk({tag, " hits_sat"}, 32'(hits_c), 0);
    endtask

    // Reset asserted between edges, with live data on f/f_valid that must be
    // ignored; outputs must clear before any edge arrives.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        f = 1'b1;
        f_valid = 1'b1;
        #1;
        reset_outputs_zero({tag, " async"});
        @(posedge clk);
        #1;
        reset_outputs_zero({tag, " held"});
        f_valid = 1'b0;
        rst = 1'b0;
        #1;
    endtask

    // Monitor: compare queued expectations just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("z_ov", 32'(z_a), 32'(e.z));
                chk("br_ov", 32'(br_a), 32'(e.br));
                chk("br_nov", 32'(br_b), 32'(e.br));
                chk("br_sat", 32'(br_c), 32'(e.br));
                chk("hits_ov", 32'(hits_a), 32'(e.h));
                chk("z_nov", 32'(z_b), 32'(e.z0));
                chk("hits_nov", 32'(hits_b), 32'(e.h0));
                chk("hits_sat", 32'(hits_c), 32'(e.hs));
                if (e.shc) begin
                    chk("shreg_ov", 32'(sh_a), 32'(e.sh));
                    chk("shreg_nov", 32'(sh_b), 32'(e.sh));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Power-on reset
        #3;
        reset_outputs_zero("por");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // 1011011 then gap then 0: overlap detects twice, non-overlap once
        step(1, 0, 8'h01, 1, 0, 0, 0, 0, 0);
        step(0, 0, 8'h02, 1, 0, 0, 0, 0, 0);
        step(1, 0, 8'h05, 1, 0, 0, 0, 0, 0);
        step(1, 1, 8'h0B, 1, 0, 1, 1, 1, 1);
        step(0, 0, 8'h16, 1, 0, 1, 0, 1, 1);
        step(1, 0, 8'h2D, 1, 0, 1, 0, 1, 1);
        step(1, 1, 8'h5B, 1, 0, 2, 0, 1, 2);
        gap(0);
        step(0, 0, 8'hB6, 1, 1, 2, 0, 1, 2);
        gap(1);

        // Byte 1,1,0,0,1,0,1,0 with idle gaps in between
        async_reset("seq_b");
        step(1, 0, 8'h01, 1, 0, 0, 0, 0, 0); gap(0);
        step(1, 0, 8'h03, 1, 0, 0, 0, 0, 0); gap(1);
        step(0, 0, 8'h06, 1, 0, 0, 0, 0, 0); gap(1);
        step(0, 0, 8'h0C, 1, 0, 0, 0, 0, 0); gap(0);
        step(1, 0, 8'h19, 1, 0, 0, 0, 0, 0); gap(0);
        step(0, 0, 8'h32, 1, 0, 0, 0, 0, 0); gap(1);
        step(1, 0, 8'h65, 1, 0, 0, 0, 0, 0); gap(0);
        step(0, 0, 8'hCA, 1, 1, 0, 0, 0, 0); gap(1);

        // 1011011011011011: five overlapping hits, 2-bit counter saturates
        async_reset("seq_c");
        step(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8'h00, 0, 0, 1, 1, 1, 1);
        step(0, 0, 8'h00, 0, 0, 1, 0, 1, 1);
        step(1, 0, 8'h00, 0, 0, 1, 0, 1, 1);
        step(1, 1, 8'h00, 0, 0, 2, 0, 1, 2);
        step(0, 0, 8'hB6, 1, 1, 2, 0, 1, 2);
        step(1, 0, 8'h00, 0, 0, 2, 0, 1, 2);
        step(1, 1, 8'h00, 0, 0, 3, 1, 2, 3);
        step(0, 0, 8'h00, 0, 0, 3, 0, 2, 3);
        step(1, 0, 8'h00, 0, 0, 3, 0, 2, 3);
        step(1, 1, 8'h00, 0, 0, 4, 0, 2, 3);
        step(0, 0, 8'h00, 0, 0, 4, 0, 2, 3);
        step(1, 0, 8'h00, 0, 0, 4, 0, 2, 3);
        step(1, 1, 8'hDB, 1, 1, 5, 1, 3, 3);

        // Partial pattern 1,0,1 then async reset mid-pattern and mid-byte
        step(1, 0, 8'h00, 0, 0, 5, 0, 3, 3);
        step(0, 0, 8'h00, 0, 0, 5, 0, 3, 3);
        step(1, 0, 8'hDD, 1, 0, 5, 0, 3, 3);
        async_reset("seq_d");

        // Fresh pattern search and fresh byte after release
        step(1, 0, 8'h01, 1, 0, 0, 0, 0, 0);
        step(0, 0, 8'h02, 1, 0, 0, 0, 0, 0);
        step(1, 0, 8'h05, 1, 0, 0, 0, 0, 0);
        step(1, 1, 8'h0B, 1, 0, 1, 1, 1, 1);
        step(0, 0, 8'h16, 1, 0, 1, 0, 1, 1);
        step(0, 0, 8'h2C, 1, 0, 1, 0, 1, 1);
        step(0, 0, 8'h58, 1, 0, 1, 0, 1, 1);
        step(0, 0, 8'hB0, 1, 1, 1, 0, 1, 1);
        gap(0);

        #5;
        chk("queue_drained", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
